// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Multi-channel conditioner for mechanical buttons and switches. Each raw pad
// level goes through a two-flop synchronizer and then a stability filter. The
// filter only adopts a new level after it has differed from the current output
// for stable_cycles_p consecutive sample ticks. Ticks come from a divider that
// all channels share.
//
// Parameters:
//   width_p         number of independent channels (>= 1)
//   stable_cycles_p ticks a new level must persist before it is adopted (>= 1)
//   tick_div_p      sample tick period in clock cycles (>= 1, 1 = every cycle)
//   reset_val_p     level loaded into synchronizers and outputs on reset
//
// Ports:
//   clk_i    single clock, rising edge
//   reset_i  synchronous active-high reset
//   btn_i    raw asynchronous pad levels, one bit per channel
//   btn_o    debounced level per channel, straight from a register
// -----------------------------------------------------------------------------
module button_debouncer #(
    parameter int   width_p         = 1,
    parameter int   stable_cycles_p = 16,
    parameter int   tick_div_p      = 1,
    parameter logic reset_val_p     = 1'b0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] btn_i,
    output logic [width_p-1:0] btn_o
);

    localparam int CNT_W = $clog2(stable_cycles_p + 1);
    // A divide-by-one divider still needs a one-bit register so the code stays
    // uniform; it simply sits at zero and the tick is permanently high.
    localparam int DIV_W = (tick_div_p > 1) ? $clog2(tick_div_p) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(stable_cycles_p - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(tick_div_p - 1);

    // ---------------------------------------------------------------- divider
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // -------------------------------------------------------------- channels
    for (genvar gi = 0; gi < width_p; gi++) begin : g_chan
        logic             sync1_q;
        logic             sync2_q;
        logic             state_q;
        logic             state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (sync2_q == state_q) begin
                // Any agreeing cycle, tick or not, cancels a pending change.
                cnt_d = '0;
            end else if (tick) begin
                if (cnt_q == CNT_LAST) begin
                    state_d = sync2_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                sync1_q <= reset_val_p;
                sync2_q <= reset_val_p;
                state_q <= reset_val_p;
                cnt_q   <= '0;
            end else begin
                sync1_q <= btn_i[gi];
                sync2_q <= sync1_q;
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign btn_o[gi] = state_q;
    end

endmodule

// File: tb/tb_button_debouncer.sv
// -----------------------------------------------------------------------------
// tb_button_debouncer
//
// Three instances with different configurations share clock and reset:
//   inst 0: stable 4, div 1, reset value 0
//   inst 1: stable 4, div 1, reset value 1
//   inst 2: stable 2, div 4, reset value 0
// A reference model predicts every output from the input history. It uses edge
// indices, with the tick count over a mismatch run taken by integer division.
// Directed scenarios pin exact edge timings with literal values. A long random
// bounce phase is then checked against the model every cycle.
// -----------------------------------------------------------------------------
module tb_button_debouncer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_a, btn_b, btn_c;
    logic [1:0] out_a, out_b, out_c;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    button_debouncer #(.width_p(2), .stable_cycles_p(4), .tick_div_p(1), .reset_val_p(1'b0))
        dut_a (.clk_i(clk), .reset_i(rst), .btn_i(btn_a), .btn_o(out_a));
    button_debouncer #(.width_p(2), .stable_cycles_p(4), .tick_div_p(1), .reset_val_p(1'b1))
        dut_b (.clk_i(clk), .reset_i(rst), .btn_i(btn_b), .btn_o(out_b));
    button_debouncer #(.width_p(2), .stable_cycles_p(2), .tick_div_p(4), .reset_val_p(1'b0))
        dut_c (.clk_i(clk), .reset_i(rst), .btn_i(btn_c), .btn_o(out_c));

    function automatic int sp(input int i);
        return (i == 2) ? 2 : 4;
    endfunction
    function automatic int dp(input int i);
        return (i == 2) ? 4 : 1;
    endfunction
    function automatic logic rvp(input int i);
        return (i == 1) ? 1'b1 : 1'b0;
    endfunction

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ reference
    // kk counts edges since the last reset edge. The filter sees at edge k the
    // input that was applied before edge k-2. A mismatch run starting at edge m
    // has seen floor((k+1)/D) - floor(m/D) ticks by edge k. The output adopts
    // the new level on the edge where that count reaches the stable count.
    int         kk;
    bit         valid = 0;
    logic [1:0] m_out [3];
    logic [1:0] m_p1  [3];
    logic [1:0] m_p2  [3];
    int         m_start [3][2];

    task automatic model_step(input logic r, input logic [1:0] v0, input logic [1:0] v1,
                              input logic [1:0] v2);
        logic [1:0] v [3];
        logic       s;
        v[0] = v0; v[1] = v1; v[2] = v2;
        if (r) begin
            valid = 1;
            kk    = 0;
            for (int i = 0; i < 3; i++) begin
                m_out[i] = {2{rvp(i)}};
                m_p1[i]  = {2{rvp(i)}};
                m_p2[i]  = {2{rvp(i)}};
                for (int c = 0; c < 2; c++) m_start[i][c] = -1;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                for (int c = 0; c < 2; c++) begin
                    s = m_p2[i][c];
                    if (s == m_out[i][c]) begin
                        m_start[i][c] = -1;
                    end else begin
                        if (m_start[i][c] < 0) m_start[i][c] = kk;
                        if ((kk + 1) / dp(i) - m_start[i][c] / dp(i) == sp(i)) begin
                            m_out[i][c]   = s;
                            m_start[i][c] = -1;
                        end
                    end
                end
                m_p2[i] = m_p1[i];
                m_p1[i] = v[i];
            end
            kk++;
        end
    endtask

    // Inputs change only on the falling edge, so values read at the rising
    // edge are exactly what the DUTs sampled.
    initial begin
        logic       r;
        logic [1:0] a, b, c;
        forever begin
            @(posedge clk);
            r = rst; a = btn_a; b = btn_b; c = btn_c;
            #1;
            model_step(r, a, b, c);
            if (valid) begin
                chk("model_a", out_a, m_out[0]);
                chk("model_b", out_b, m_out[1]);
                chk("model_c", out_c, m_out[2]);
            end
        end
    end

    // ------------------------------------------------------------- stimulus
    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        rst = 1'b1; btn_a = a; btn_b = b; btn_c = c;
        edges(1);
        rst = 1'b0;
    endtask

    int         hold [3][2];
    logic [1:0] cur  [3];
    bit         train_hit;

    initial begin
        rst = 1'b0; btn_a = 2'b00; btn_b = 2'b00; btn_c = 2'b00;
        edges(1);

        // Reset values and clean press latency on all three configurations.
        do_reset(2'b00, 2'b00, 2'b00);
        chk("rst_a", out_a, 2'b00);
        chk("rst_b", out_b, 2'b11);
        chk("rst_c", out_c, 2'b00);
        btn_a = 2'b01; btn_b = 2'b00; btn_c = 2'b01;
        edges(5);
        chk("press_a_e4", out_a, 2'b00);
        chk("rstval_b_e4", out_b, 2'b11);
        edges(1);
        chk("press_a_e5", out_a, 2'b01);
        chk("rstval_b_e5", out_b, 2'b00);
        edges(1);
        chk("div_c_e6", out_c, 2'b00);
        edges(1);
        chk("div_c_e7", out_c, 2'b01);

        // Both channels together, then one channel alone.
        do_reset(2'b11, 2'b00, 2'b00);
        edges(5);
        chk("both_e4", out_a, 2'b00);
        edges(1);
        chk("both_e5", out_a, 2'b11);
        btn_a = 2'b01;
        edges(5);
        chk("ch1_fall_e4", out_a, 2'b11);
        edges(1);
        chk("ch1_fall_e5", out_a, 2'b01);

        // Bounce: 1,1,1,0 then steady 1; flip lands 6 edges after the last rise.
        do_reset(2'b00, 2'b00, 2'b00);
        btn_a = 2'b01; edges(3);
        btn_a = 2'b00; edges(1);
        btn_a = 2'b01; edges(5);
        chk("bounce_e8", out_a, 2'b00);
        edges(1);
        chk("bounce_e9", out_a, 2'b01);

        // Pulse train of three highs and one low must never set the output.
        do_reset(2'b00, 2'b00, 2'b00);
        train_hit = 0;
        repeat (10) begin
            btn_a = 2'b01;
            repeat (3) begin edges(1); if (out_a[0]) train_hit = 1; end
            btn_a = 2'b00;
            edges(1); if (out_a[0]) train_hit = 1;
        end
        chk("pulse_train", {1'b0, train_hit}, 2'b00);

        // Divider: a one-cycle glitch restarts the tick count.
        do_reset(2'b00, 2'b00, 2'b00);
        btn_c = 2'b01; edges(4);
        btn_c = 2'b00; edges(1);
        btn_c = 2'b01; edges(6);
        chk("glitch_c_e10", out_c, 2'b00);
        edges(1);
        chk("glitch_c_e11", out_c, 2'b01);

        // Reset one edge before the flip discards the pending count.
        do_reset(2'b00, 2'b00, 2'b00);
        btn_a = 2'b01; edges(4);
        rst = 1'b1; edges(1);
        chk("midrst_hold", out_a, 2'b00);
        rst = 1'b0;
        edges(5);
        chk("midrst_e4", out_a, 2'b00);
        edges(1);
        chk("midrst_e5", out_a, 2'b01);

        // Random bouncing levels with occasional resets.
        do_reset(2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 3; i++) begin
            cur[i] = 2'b00;
            for (int c = 0; c < 2; c++) hold[i][c] = 0;
        end
        repeat (4000) begin
            for (int i = 0; i < 3; i++) begin
                for (int c = 0; c < 2; c++) begin
                    if (hold[i][c] == 0) begin
                        cur[i][c]  = 1'($urandom_range(0, 1));
                        hold[i][c] = int'($urandom_range(1, 14));
                    end else begin
                        hold[i][c]--;
                    end
                end
            end
            btn_a = cur[0]; btn_b = cur[1]; btn_c = cur[2];
            rst   = ($urandom_range(0, 299) == 0);
            edges(1);
        end
        rst = 1'b0;
        edges(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
